muladd_feeder: RTL and testbench
================================

# muladd_feeder

Upstream stage for the `muladd` HLS kernel. It accepts a frame of SIZE `(a, b)` sample pairs over a valid/ready stream and buffers them in two local RAMs. It then drives the kernel's ap_ctrl_hs start handshake and serves the kernel's `a`/`b` memory-port reads with 1-cycle latency. It captures `ap_return` on `ap_done` and presents the result on a valid/ready output stream.

## Interface
- `SIZE`, 16, frame length in sample pairs (2..2^AW)
- `AW`, 4, kernel address width
- `DW`, 16, sample width
- `RW`, 32, result width
- `ap_clk`  in  1  sole clock, rising edge
- `ap_rst_n`  in  1  reset; one clock, asynchronous, active-low
- `s_valid`  in  1  input pair valid
- `s_ready`  out  1  input pair accepted when `s_valid && s_ready`
- `s_a_data`  in  DW  sample for RAM a
- `s_b_data`  in  DW  sample for RAM b
- `m_valid`  out  1  result valid
- `m_ready`  in  1  result consumed when `m_valid && m_ready`
- `m_data`  out  RW  captured kernel result
- `k_start`  out  1  to kernel `ap_start`
- `k_done`  in  1  from kernel `ap_done`
- `k_ready`  in  1  from kernel `ap_ready`
- `k_idle`  in  1  from kernel `ap_idle`; status only, ignored by FSM
- `k_a_address0`, `k_b_address0`  in  AW  kernel read addresses
- `k_a_ce0`, `k_b_ce0`  in  1  kernel read enables
- `k_a_q0`, `k_b_q0`  out  DW  read data
- `k_return`  in  RW  from kernel `ap_return`
- `busy`  out  1  high in any state other than LOAD
- `frame_cnt`  out  16  completed output handshakes, wraps at 2^16

## Operation
- FSM states: LOAD, START, RUN, OUT. Reset state is LOAD.
- LOAD:
  - `s_ready=1`.
  - Each accepted pair is written to `a_mem[idx]`/`b_mem[idx]` and increments `idx`.
  - When the pair with `idx==SIZE-1` is accepted: `idx<=0`, go to START.
- START:
  - `k_start=1`, held until `k_ready` is sampled high.
  - `k_ready && !k_done`: go to RUN.
  - `k_ready && k_done`: capture `m_data<=k_return`, go to OUT.
- RUN:
  - `k_start=0`.
  - On `k_done`: capture `m_data<=k_return`, go to OUT.
- OUT:
  - `m_valid=1`; `m_data` is stable.
  - On `m_ready`: `frame_cnt++`, go to LOAD.
- `k_done` or `k_ready` outside START/RUN is ignored.
- Read ports are independent of FSM state:
  - `k_x_q0 <= x_mem[k_x_address0]` when `k_x_ce0`; otherwise hold.
  - Address ≥ SIZE returns 0.
- RAM contents are not reset. Contents are stable from leaving LOAD until re-entering LOAD; writes occur only in LOAD.
- `s_ready`, `k_start`, `m_valid`, `busy` are decoded from the state register only. No combinational path from any input.

## Timing
- Reset values:
  - `s_ready=1` (state LOAD), `m_valid=0`, `m_data=0`, `k_start=0`
  - `k_a_q0=k_b_q0=0`, `busy=0`, `frame_cnt=0`, `idx=0`
- Reset assertion at any time:
  - Immediately forces all of the above.
  - Any partial frame or in-flight kernel result is discarded.
- Input throughput: 1 pair per cycle in LOAD. SIZE-cycle minimum load for a gapless stream.
- `k_start` rises the cycle after the last pair is accepted.
- Read latency: exactly 1 cycle from `ce0` sampled high to `q0` valid.
- `m_valid` rises the cycle after `k_done` is sampled.
- `s_ready` rises the cycle after the output handshake.
- Minimum frame period: SIZE + 1 (START) + kernel latency + 1 (OUT) cycles.

## Test plan
- Gapless load:
  - Stimulus: `a=i`, `b=i+1` for i=0..15; behavioural muladd kernel model; `m_ready=1`.
  - Required: `m_data=0x00000550`, one-cycle `m_valid`, `frame_cnt=1`, `k_start` high until `k_ready`.
- Backpressure:
  - Stimulus: `s_valid` toggling 1/0; `m_ready=0` for 5 cycles after `m_valid`.
  - Required: `m_data` stable at `0x550` throughout; `s_ready=0` until the handshake; the next frame loads only afterwards.
- Collapsed handshake:
  - Stimulus: kernel model asserts `k_ready` and `k_done` in the first START cycle with `k_return=0x1234`.
  - Required: no RUN cycle; `m_data=0x00001234` next cycle.
- Read port:
  - Stimulus: after a frame load, `k_a_ce0=1`, `addr=3`; then `ce0=0`.
  - Required: `k_a_q0=3` one cycle later and held; `k_b_q0` likewise returns 4.
- Mid-load reset:
  - Stimulus: assert `ap_rst_n=0` after 7 pairs; release; load 16 pairs `a=1,b=2`.
  - Required: all reset values during reset; `m_data=0x00000020`; `frame_cnt=1`.

Source files
------------

// File: rtl/muladd_feeder.sv
`default_nettype none
// ============================================================================
// Module      : muladd_feeder
// Description : Buffers a frame of (a, b) sample pairs in two local RAMs.
//               Starts the muladd kernel with the ap_ctrl_hs handshake and
//               serves its a/b memory-port reads with 1-cycle latency.
//               Returns the captured ap_return on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module muladd_feeder #(
   parameter int SIZE = 16,
   parameter int AW   = 4,
   parameter int DW   = 16,
   parameter int RW   = 32
) (
   input  logic          ap_clk,
   input  logic          ap_rst_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_a_data,
   input  logic [DW-1:0] s_b_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [RW-1:0] m_data,
   output logic          k_start,
   input  logic          k_done,
   input  logic          k_ready,
   input  logic          k_idle,
   input  logic [AW-1:0] k_a_address0,
   input  logic [AW-1:0] k_b_address0,
   input  logic          k_a_ce0,
   input  logic          k_b_ce0,
   output logic [DW-1:0] k_a_q0,
   output logic [DW-1:0] k_b_q0,
   input  logic [RW-1:0] k_return,
   output logic          busy,
   output logic [15:0]   frame_cnt
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   localparam logic [AW-1:0] c_last_idx = AW'(SIZE - 1);
   localparam logic [AW:0]   c_size     = (AW + 1)'(SIZE);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_capture;
   logic          w_s_fire;
   logic          w_last_pair;
   logic [AW-1:0] r_idx;
   logic [RW-1:0] r_m_data;
   logic [15:0]   r_frame_cnt;
   logic [DW-1:0] r_a_q0;
   logic [DW-1:0] r_b_q0;
   logic [DW-1:0] r_a_mem [0:SIZE-1];
   logic [DW-1:0] r_b_mem [0:SIZE-1];

   // Kernel idle is informational only; the handshake relies on ap_ready/ap_done.
   logic w_unused_idle;
   assign w_unused_idle = k_idle;

   // Pairs are accepted only in LOAD, so the fire condition needs no s_ready feedback.
   assign w_s_fire    = (r_state == ST_LOAD) && s_valid;
   assign w_last_pair = w_s_fire && (r_idx == c_last_idx);

   // Next-state, result-capture strobe, and state-decoded stream/kernel controls.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      s_ready     = (r_state == ST_LOAD);
      k_start     = (r_state == ST_START);
      m_valid     = (r_state == ST_OUT);
      busy        = (r_state != ST_LOAD);
      case (r_state)
         ST_LOAD: begin
            if (w_last_pair) w_state_nxt = ST_START;
         end
         ST_START: begin
            // ap_ready and ap_done may arrive together: skip RUN entirely.
            if (k_ready) begin
               if (k_done) begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_OUT;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (k_done) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            if (m_ready) w_state_nxt = ST_LOAD;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // State register, load index, captured result and frame counter.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state     <= ST_LOAD;
         r_idx       <= '0;
         r_m_data    <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_s_fire) begin
            r_idx <= w_last_pair ? '0 : r_idx + 1'b1;
         end
         if (w_capture) begin
            r_m_data <= k_return;
         end
         if ((r_state == ST_OUT) && m_ready) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   // Sample RAMs: written only while loading, contents deliberately not reset.
   always_ff @(posedge ap_clk) begin
      if (w_s_fire) begin
         r_a_mem[r_idx] <= s_a_data;
         r_b_mem[r_idx] <= s_b_data;
      end
   end

   // Kernel read ports: 1-cycle latency, hold when ce0 is low, zero beyond SIZE.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_a_q0 <= '0;
         r_b_q0 <= '0;
      end else begin
         if (k_a_ce0) begin
            r_a_q0 <= ({1'b0, k_a_address0} < c_size) ? r_a_mem[k_a_address0] : '0;
         end
         if (k_b_ce0) begin
            r_b_q0 <= ({1'b0, k_b_address0} < c_size) ? r_b_mem[k_b_address0] : '0;
         end
      end
   end

   assign m_data    = r_m_data;
   assign frame_cnt = r_frame_cnt;
   assign k_a_q0    = r_a_q0;
   assign k_b_q0    = r_b_q0;

endmodule
`default_nettype wire

// File: tb/tb_muladd_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_muladd_feeder
// Description : Self-checking bench for muladd_feeder with a behavioural
//               muladd kernel and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muladd_feeder;

   localparam int SIZE = 16;
   localparam int AW   = 4;
   localparam int DW   = 16;
   localparam int RW   = 32;

   logic          ap_clk   = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          s_valid  = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_a_data = '0;
   logic [DW-1:0] s_b_data = '0;
   logic          m_valid;
   logic          m_ready  = 1'b0;
   logic [RW-1:0] m_data;
   logic          k_start;
   logic          k_done   = 1'b0;
   logic          k_ready  = 1'b0;
   logic          k_idle   = 1'b1;
   logic [AW-1:0] k_a_address0;
   logic [AW-1:0] k_b_address0;
   logic          k_a_ce0;
   logic          k_b_ce0;
   logic [DW-1:0] k_a_q0;
   logic [DW-1:0] k_b_q0;
   logic [RW-1:0] k_return = '0;
   logic          busy;
   logic [15:0]   frame_cnt;

   // kernel-model and bench-driven read port sources
   logic [AW-1:0] km_addr  = '0;
   logic          km_ce    = 1'b0;
   logic [AW-1:0] tb_addr  = '0;
   logic          tb_ce    = 1'b0;
   logic          tb_rd_en = 1'b0;
   bit            kernel_en = 1'b1;
   bit            collapse  = 1'b0;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [RW-1:0] exp_q[$];

   assign k_a_address0 = tb_rd_en ? tb_addr : km_addr;
   assign k_b_address0 = tb_rd_en ? tb_addr : km_addr;
   assign k_a_ce0      = tb_rd_en ? tb_ce   : km_ce;
   assign k_b_ce0      = tb_rd_en ? tb_ce   : km_ce;

   muladd_feeder #(.SIZE(SIZE), .AW(AW), .DW(DW), .RW(RW)) dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_a_data     (s_a_data),
      .s_b_data     (s_b_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .k_start      (k_start),
      .k_done       (k_done),
      .k_ready      (k_ready),
      .k_idle       (k_idle),
      .k_a_address0 (k_a_address0),
      .k_b_address0 (k_b_address0),
      .k_a_ce0      (k_a_ce0),
      .k_b_ce0      (k_b_ce0),
      .k_a_q0       (k_a_q0),
      .k_b_q0       (k_b_q0),
      .k_return     (k_return),
      .busy         (busy),
      .frame_cnt    (frame_cnt)
   );

   always #5 ap_clk = ~ap_clk;

   // Behavioural muladd kernel: ap_ready after a short delay, then sum of a[i]*b[i].
   initial begin : kernel_model
      logic [RW-1:0] acc;
      forever begin
         @(negedge ap_clk);
         if (k_start && kernel_en && ap_rst_n) begin
            if (collapse) begin
               k_ready  = 1'b1;
               k_done   = 1'b1;
               k_return = 32'h0000_1234;
               @(negedge ap_clk);
               k_ready  = 1'b0;
               k_done   = 1'b0;
            end else begin
               repeat (2) begin
                  @(negedge ap_clk);
                  n_tests++;
                  if (k_start !== 1'b1) begin
                     n_fail++;
                     $display("FAIL k_start_hold: got %b, want 1", k_start);
                  end
               end
               k_ready = 1'b1;
               @(negedge ap_clk);
               k_ready = 1'b0;
               n_tests++;
               if (k_start !== 1'b0) begin
                  n_fail++;
                  $display("FAIL k_start_drop: got %b, want 0", k_start);
               end
               acc     = '0;
               km_addr = '0;
               km_ce   = 1'b1;
               for (int i = 0; i < SIZE; i++) begin
                  @(negedge ap_clk);
                  acc = acc + 32'(k_a_q0) * 32'(k_b_q0);
                  if (i < SIZE - 1) km_addr = AW'(i + 1);
                  else              km_ce   = 1'b0;
               end
               k_return = acc;
               k_done   = 1'b1;
               @(negedge ap_clk);
               k_done   = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive n pairs (0: a=i,b=i+1  1: a=1,b=2  2: random); full frames push the expected result.
   task automatic load_frame(input int mode, input bit gaps, input int n);
      logic [RW-1:0] sum;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      sum = '0;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            s_valid = 1'b0;
            @(negedge ap_clk);
         end
         case (mode)
            0:       begin a = DW'(i);             b = DW'(i + 1); end
            1:       begin a = 16'd1;              b = 16'd2;      end
            default: begin a = DW'($urandom);      b = DW'($urandom); end
         endcase
         s_valid  = 1'b1;
         s_a_data = a;
         s_b_data = b;
         n_tests++;
         if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL s_ready_load: pair %0d got %b, want 1", i, s_ready);
         end
         sum = sum + 32'(a) * 32'(b);
         @(negedge ap_clk);
      end
      s_valid = 1'b0;
      if (n == SIZE) exp_q.push_back(collapse ? 32'h0000_1234 : sum);
   endtask

   task automatic wait_mvalid(input string tag, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (m_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge ap_clk);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: m_valid never rose, want 1", tag);
      end
   endtask

   task automatic check_reset_values(input string tag);
      n_tests++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 32'h0 || k_start !== 1'b0 ||
          k_a_q0 !== 16'h0 || k_b_q0 !== 16'h0 || busy !== 1'b0 || frame_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL %s: s_ready=%b m_valid=%b m_data=%h k_start=%b qa=%h qb=%h busy=%b cnt=%0d, want 1 0 0 0 0 0 0 0",
                  tag, s_ready, m_valid, m_data, k_start, k_a_q0, k_b_q0, busy, frame_cnt);
      end
   endtask

   task automatic test_reset;
      check_reset_values("reset_state");
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check_reset_values("after_release");
   endtask

   task automatic test_gapless;
      bit ok;
      logic [RW-1:0] exp;
      m_ready = 1'b1;
      load_frame(0, 1'b0, SIZE);
      n_tests++;
      if (k_start !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL gapless_start: k_start=%b busy=%b s_ready=%b, want 1 1 0", k_start, busy, s_ready);
      end
      wait_mvalid("gapless", ok);
      if (ok) begin
         exp = exp_q.pop_front();
         n_tests++;
         if (m_data !== exp || exp !== 32'h0000_0550) begin
            n_fail++;
            $display("FAIL gapless_data: got %h, want 00000550 (model %h)", m_data, exp);
         end
         @(negedge ap_clk);
         n_tests++;
         if (m_valid !== 1'b0 || frame_cnt !== 16'd1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL gapless_after: m_valid=%b cnt=%0d s_ready=%b, want 0 1 1", m_valid, frame_cnt, s_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      logic [RW-1:0] exp;
      m_ready = 1'b0;
      load_frame(0, 1'b1, SIZE);
      wait_mvalid("bp", ok);
      if (ok) begin
         repeat (5) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== exp_q[0] || s_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_stall: m_valid=%b m_data=%h s_ready=%b, want 1 %h 0", m_valid, m_data, s_ready, exp_q[0]);
            end
            @(negedge ap_clk);
         end
         m_ready = 1'b1;
         exp = exp_q.pop_front();
         n_tests++;
         if (m_data !== exp) begin
            n_fail++;
            $display("FAIL bp_data: got %h, want %h", m_data, exp);
         end
         @(negedge ap_clk);
         n_tests++;
         if (m_valid !== 1'b0 || frame_cnt !== 16'd2 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after: m_valid=%b cnt=%0d s_ready=%b, want 0 2 1", m_valid, frame_cnt, s_ready);
         end
      end
   endtask

   task automatic test_collapsed;
      logic [RW-1:0] exp;
      m_ready  = 1'b1;
      collapse = 1'b1;
      load_frame(2, 1'b0, SIZE);
      n_tests++;
      if (k_start !== 1'b1) begin
         n_fail++;
         $display("FAIL collapse_start: k_start=%b, want 1", k_start);
      end
      @(negedge ap_clk);
      exp = exp_q.pop_front();
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== exp) begin
         n_fail++;
         $display("FAIL collapse_out: m_valid=%b m_data=%h, want 1 %h", m_valid, m_data, exp);
      end
      collapse = 1'b0;
      @(negedge ap_clk);
      n_tests++;
      if (frame_cnt !== 16'd3 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL collapse_cnt: cnt=%0d m_valid=%b, want 3 0", frame_cnt, m_valid);
      end
   endtask

   task automatic test_read_port;
      bit ok;
      logic [RW-1:0] exp;
      kernel_en = 1'b0;
      m_ready   = 1'b1;
      load_frame(0, 1'b0, SIZE);
      tb_rd_en = 1'b1;
      tb_addr  = 4'd3;
      tb_ce    = 1'b1;
      @(negedge ap_clk);
      n_tests++;
      if (k_a_q0 !== 16'd3 || k_b_q0 !== 16'd4) begin
         n_fail++;
         $display("FAIL read_port: qa=%0d qb=%0d, want 3 4", k_a_q0, k_b_q0);
      end
      tb_ce   = 1'b0;
      tb_addr = 4'd9;
      @(negedge ap_clk);
      n_tests++;
      if (k_a_q0 !== 16'd3 || k_b_q0 !== 16'd4) begin
         n_fail++;
         $display("FAIL read_hold: qa=%0d qb=%0d, want 3 4", k_a_q0, k_b_q0);
      end
      tb_rd_en  = 1'b0;
      kernel_en = 1'b1;
      wait_mvalid("read", ok);
      if (ok) begin
         exp = exp_q.pop_front();
         n_tests++;
         if (m_data !== exp) begin
            n_fail++;
            $display("FAIL read_result: got %h, want %h", m_data, exp);
         end
         @(negedge ap_clk);
         n_tests++;
         if (frame_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL read_cnt: got %0d, want 4", frame_cnt);
         end
      end
   endtask

   task automatic test_mid_load_reset;
      bit ok;
      logic [RW-1:0] exp;
      load_frame(2, 1'b0, 7);
      ap_rst_n = 1'b0;
      #1;
      check_reset_values("midload_reset_async");
      @(negedge ap_clk);
      check_reset_values("midload_reset_held");
      ap_rst_n = 1'b1;
      m_ready  = 1'b1;
      load_frame(1, 1'b0, SIZE);
      wait_mvalid("midload", ok);
      if (ok) begin
         exp = exp_q.pop_front();
         n_tests++;
         if (m_data !== exp || exp !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL midload_data: got %h, want 00000020 (model %h)", m_data, exp);
         end
         @(negedge ap_clk);
         n_tests++;
         if (frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL midload_cnt: got %0d, want 1", frame_cnt);
         end
      end
   endtask

   initial begin : main
      repeat (2) @(negedge ap_clk);
      test_reset();
      test_gapless();
      test_backpressure();
      test_collapsed();
      test_read_port();
      test_mid_load_reset();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
